// File: rtl/wb_irq_responder.sv
// Interrupt responder for one bus priority level: request combine, vector, iack.
// Optional round-robin arbitration is enabled by defining IRQ_ROUND_ROBIN_EN.
module wb_irq_responder #(
  parameter logic [8:0] VEC0      = 9'o060,
  parameter logic [8:0] VEC1      = 9'o064,
  parameter logic [8:0] VEC2      = 9'o070,
  parameter logic [8:0] VEC3      = 9'o074,
  parameter logic [8:0] STRAY_VEC = 9'o000
) (
  input  logic       clk_p,
  input  logic       rst,
  input  logic [3:0] src_req,
  output logic [3:0] src_ack,
  output logic       irq_o,
  input  logic       istb_i,
  output logic [8:0] ivec_o,
  output logic       iack_o
);

  typedef enum logic [1:0] {IDLE, ARB, ACK, HOLD} state_t;

  state_t     state_q, state_d;
  logic       istb_q;
  logic [1:0] sel_q, sel_d;
  logic       none_q, none_d;
  logic       irq_q, irq_d;
  logic       iack_q, iack_d;
  logic [8:0] ivec_q, ivec_d;
  logic [3:0] ack_q, ack_d;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] win;
  logic [8:0] win_vec;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] dbl;
`endif

  // Rotate requests so the source after the last-served one sits at bit 0.
  always_comb begin
`ifdef IRQ_ROUND_ROBIN_EN
    dbl = {src_req, src_req};
    rot = dbl[3'(ptr_q) + 3'd1 +: 4];
`else
    rot = src_req;
`endif
    off = 2'd0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
`ifdef IRQ_ROUND_ROBIN_EN
    win = ptr_q + 2'd1 + off;
`else
    win = off;
`endif
  end

  always_comb begin
    win_vec = VEC0;
    unique case (win)
      2'd0: win_vec = VEC0;
      2'd1: win_vec = VEC1;
      2'd2: win_vec = VEC2;
      2'd3: win_vec = VEC3;
    endcase
  end

  always_ff @(posedge clk_p) begin
    istb_q <= istb_i;
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      none_q  <= 1'b0;
      irq_q   <= 1'b0;
      iack_q  <= 1'b0;
      ivec_q  <= 9'd0;
      ack_q   <= 4'd0;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr_q   <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      none_q  <= none_d;
      irq_q   <= irq_d;
      iack_q  <= iack_d;
      ivec_q  <= ivec_d;
      ack_q   <= ack_d;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (istb_i && !istb_q) state_d = ARB;
      ARB:  state_d = ACK;
      ACK:  state_d = HOLD;
      HOLD: if (!istb_i) state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d  = sel_q;
    none_d = none_q;
    iack_d = iack_q;
    ivec_d = ivec_q;
    ack_d  = 4'd0;
    // Masked outside IDLE so a second request cannot race the device clear.
    irq_d  = (state_d == IDLE) && (|src_req);
`ifdef IRQ_ROUND_ROBIN_EN
    ptr_d  = ptr_q;
`endif
    unique case (state_q)
      IDLE: ;
      ARB: begin
        sel_d  = win;
        none_d = (src_req == 4'd0);
        ivec_d = (src_req == 4'd0) ? STRAY_VEC : win_vec;
      end
      ACK: begin
        iack_d = 1'b1;
        if (!none_q) begin
          ack_d = 4'b0001 << sel_q;
`ifdef IRQ_ROUND_ROBIN_EN
          ptr_d = sel_q;
`endif
        end
      end
      HOLD: begin
        if (!istb_i) begin
          iack_d = 1'b0;
          ivec_d = 9'd0;
        end
      end
    endcase
  end

  assign src_ack = ack_q;
  assign irq_o   = irq_q;
  assign ivec_o  = ivec_q;
  assign iack_o  = iack_q;

endmodule
